// File: rtl/pc_pkg.sv
// Shared types and defaults for the program counter slice.
// Optional feature macro: PC_STALL_EN (adds the stall hold input).
package pc_pkg;

  localparam int PC_WIDTH = 8;
  localparam int PC_STEP  = 1;

  typedef logic [PC_WIDTH-1:0] pc_t;

  typedef enum logic {
    PC_SRC_SEQ    = 1'b0,
    PC_SRC_BRANCH = 1'b1
  } pc_src_e;

  localparam pc_t PC_RESET_VECTOR = 8'h00;

endpackage

// File: rtl/program_counter_if.sv
// Bus between control/branch logic and the program counter.
// Optional feature macro: PC_STALL_EN (adds the stall signal).
interface program_counter_if
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
);

  logic [WIDTH-1:0] immediate;
  logic             PCSrc;
`ifdef PC_STALL_EN
  logic             stall;
`endif
  logic [WIDTH-1:0] pc;

  // Control side: drives next-PC controls, observes the current PC.
  modport master (
    output immediate,
    output PCSrc,
`ifdef PC_STALL_EN
    output stall,
`endif
    input  pc
  );

  // Program counter side.
  modport slave (
    input  immediate,
    input  PCSrc,
`ifdef PC_STALL_EN
    input  stall,
`endif
    output pc
  );

endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC computation: sequential and PC-relative adders
// plus the select mux. All sums wrap modulo 2^WIDTH.
module pc_next_logic
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int STEP  = PC_STEP
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] immediate,
  input  logic             PCSrc,
  output logic [WIDTH-1:0] pc_next
);

  logic [WIDTH-1:0] w_pc_seq;
  logic [WIDTH-1:0] w_pc_branch;

  // Two's-complement add of the offset is the same bit pattern as an
  // unsigned add, so negative offsets move backward with carry dropped.
  assign w_pc_seq    = pc + WIDTH'(STEP);
  assign w_pc_branch = pc + immediate;

  // Select the next address from the branch decision.
  always_comb begin
    pc_next = w_pc_seq;
    case (pc_src_e'(PCSrc))
      PC_SRC_SEQ:    pc_next = w_pc_seq;
      PC_SRC_BRANCH: pc_next = w_pc_branch;
      default:       pc_next = w_pc_seq;
    endcase
  end

endmodule

// File: rtl/program_counter.sv
// Program counter register of the single-cycle datapath.
// Optional feature macro: PC_STALL_EN (stall = 1 holds pc; reset wins).
module program_counter
  import pc_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH,
  parameter int               STEP         = PC_STEP,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
  input  logic               CLK,
  input  logic               reset,
  program_counter_if.slave   bus
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_next;

  pc_next_logic #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_pc_next_logic (
    .pc        (r_pc),
    .immediate (bus.immediate),
    .PCSrc     (bus.PCSrc),
    .pc_next   (w_pc_next)
  );

  // PC register: async active-low reset, otherwise load next PC each edge.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_VECTOR;
    end else begin
`ifdef PC_STALL_EN
      if (bus.stall) begin
        r_pc <= r_pc;
      end else begin
        r_pc <= w_pc_next;
      end
`else
      r_pc <= w_pc_next;
`endif
    end
  end

  // Output straight from the flop so pc has no combinational path.
  assign bus.pc = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter (default parameters).
// Build with PC_STALL_EN defined to also exercise the stall hold.
module tb_program_counter;

  logic clk;
  logic reset;

  int total;
  int bad;
  int model_pc;

  typedef struct {
    logic       src;
    logic [7:0] imm;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  program_counter_if #(.WIDTH(8)) bus ();

  program_counter dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [7:0] exp);
    total++;
    if (bus.pc !== exp) begin
      bad++;
      $display("FAIL %s: pc got %h want %h at t=%0t", name, bus.pc, exp, $time);
    end
  endtask

  // Reference next-PC from the architectural rule, using signed offset
  // arithmetic reduced modulo 256.
  function automatic int ref_next(input int cur, input logic src, input logic [7:0] imm);
    int sum;
    if (src) sum = cur + int'($signed(imm));
    else     sum = cur + 1;
    return ((sum % 256) + 256) % 256;
  endfunction

  // Present inputs just after a rising edge, let one edge happen, check.
  task automatic do_edge(input logic src, input logic [7:0] imm, input logic stl,
                         input string name, input logic use_exp, input logic [7:0] exp);
    logic hold;
    hold = stl;
`ifndef PC_STALL_EN
    hold = 1'b0;
`endif
    bus.PCSrc     = src;
    bus.immediate = imm;
`ifdef PC_STALL_EN
    bus.stall     = stl;
`endif
    @(posedge clk);
    if (!reset)     model_pc = 0;
    else if (!hold) model_pc = ref_next(model_pc, src, imm);
    #1;
    check({name, "_model"}, 8'(model_pc));
    if (use_exp) check(name, exp);
  endtask

  initial begin
    total = 0;
    bad = 0;
    model_pc = 0;
    bus.PCSrc = 1'b1;
    bus.immediate = 8'h01;
`ifdef PC_STALL_EN
    bus.stall = 1'b0;
`endif
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("reset_async", 8'h00);

    // Reset held across edges with a branch request pending: no update.
    do_edge(1'b1, 8'h01, 1'b0, "reset_hold0", 1'b1, 8'h00);
    do_edge(1'b1, 8'h01, 1'b0, "reset_hold1", 1'b1, 8'h00);
    reset = 1'b1;

    // Directed table: sequential, forward, backward, wrap, self-loop.
    vecs.push_back('{1'b0, 8'h00, 8'h01});
    vecs.push_back('{1'b0, 8'h00, 8'h02});
    vecs.push_back('{1'b0, 8'h00, 8'h03});
    vecs.push_back('{1'b0, 8'h00, 8'h04});
    vecs.push_back('{1'b1, 8'h01, 8'h05});
    vecs.push_back('{1'b1, 8'h03, 8'h08});
    vecs.push_back('{1'b1, 8'h04, 8'h0C});
    vecs.push_back('{1'b1, 8'hF8, 8'h04});
    vecs.push_back('{1'b1, 8'h7F, 8'h83});
    vecs.push_back('{1'b1, 8'h7C, 8'hFF});
    vecs.push_back('{1'b0, 8'h55, 8'h00});
    vecs.push_back('{1'b1, 8'h02, 8'h02});
    vecs.push_back('{1'b1, 8'hFC, 8'hFE});
    vecs.push_back('{1'b1, 8'h00, 8'hFE});
    vecs.push_back('{1'b1, 8'h0A, 8'h08});
    for (int i = 0; i < vecs.size(); i++) begin
      do_edge(vecs[i].src, vecs[i].imm, 1'b0, $sformatf("vec%0d", i), 1'b1, vecs[i].exp);
    end

    // Input glitches between edges must not reach pc (pc = 8 here).
    #4;
    bus.PCSrc = 1'b0;
    bus.immediate = 8'h77;
    #1;
    check("glitch_between_edges", 8'h08);
    bus.PCSrc = 1'b1;
    bus.immediate = 8'h0A;

    // Asynchronous reset mid-cycle while pc = 8.
    #4;
    reset = 1'b0;
    model_pc = 0;
    #1;
    check("reset_midcycle", 8'h00);
    do_edge(1'b1, 8'h01, 1'b0, "reset_mid_hold", 1'b1, 8'h00);
    reset = 1'b1;
    do_edge(1'b0, 8'h00, 1'b0, "first_after_reset", 1'b1, 8'h01);

`ifdef PC_STALL_EN
    // Stall hold at pc = 5 with a pending branch of +3.
    do_edge(1'b1, 8'h04, 1'b0, "stall_setup", 1'b1, 8'h05);
    for (int i = 0; i < 3; i++) begin
      do_edge(1'b1, 8'h03, 1'b1, $sformatf("stall_hold%0d", i), 1'b1, 8'h05);
    end
    do_edge(1'b1, 8'h03, 1'b0, "stall_release", 1'b1, 8'h08);
    // Reset has priority over stall.
    reset = 1'b0;
    model_pc = 0;
    #1;
    check("stall_reset_prio", 8'h00);
    do_edge(1'b1, 8'h03, 1'b1, "stall_reset_hold", 1'b1, 8'h00);
    reset = 1'b1;
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      do_edge(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 3) == 0), "rand", 1'b0, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_counter.md
# program_counter

Program counter of the single-cycle RISC-V datapath. It holds the current instruction address `pc` and updates it on every rising clock edge. The next value is either the sequential address `pc + STEP` or the PC-relative branch/jump target `pc + immediate`. `pc` drives the instruction-memory address and the branch-target adder; `PCSrc` comes from the control/branch logic.

## Interface
- `WIDTH`, default 8: address width in bits; also the width of `immediate`.
- `STEP`, default 1: sequential increment (word-addressed instruction memory).
- `RESET_VECTOR`, default 0: value loaded into `pc` by reset.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `immediate`  in  WIDTH  signed two's-complement branch offset.
- `PCSrc`  in  1  next-PC select: 1 = `pc + immediate`, 0 = `pc + STEP`.
- `stall`  in  1  hold `pc`; present only when `PC_STALL_EN` is defined.
- `pc`  out  WIDTH  current PC, driven directly from the register.

## Operation
- Next-PC value: `pc_next = PCSrc ? (pc + immediate) : (pc + STEP)`.
- All arithmetic is modulo 2^WIDTH.
  - Carry-out is discarded; there is no overflow flag.
  - 0xFF + 1 = 0x00.
  - 0x02 + 0xFC = 0xFE.
- `immediate` is interpreted as signed. Adding a negative offset moves the PC backward. With WIDTH = 8 the reach is −128…+127.
- `immediate` = 0 with `PCSrc` = 1 holds `pc` (self-loop).
- While `reset` = 0, `pc` = `RESET_VECTOR`, regardless of `CLK`, `PCSrc`, `immediate` or `stall`.
- `PCSrc` and `immediate` are sampled only at the rising edge. Glitches between edges have no effect.
- The block contains no state other than the `pc` register.

## Timing
- Update latency: 1 cycle. Inputs present before rising edge N determine `pc` immediately after edge N.
- Reset assertion (falling edge of `reset`) forces `pc` to `RESET_VECTOR` immediately, without waiting for a clock edge. This includes assertion in the middle of a cycle.
- Reset release:
  - The first update happens at the first rising `CLK` edge after `reset` = 1.
  - That update computes from `RESET_VECTOR`, so with defaults the first post-reset value is 1 (if `PCSrc` = 0).
  - `reset` must be deasserted synchronously to `CLK`, meeting recovery/removal time; the synchronizer is external.
- `pc` is glitch-free: a pure register output with no combinational path from inputs.
- The bench clock has a 20-unit period. Stimulus changes on rising edges; the resulting `pc` is checked before the next edge.

## Configuration
- Macro: `PC_STALL_EN`.
- When defined:
  - The `stall` input port exists.
  - `stall` = 1 at a rising edge keeps `pc` unchanged, ignoring `PCSrc` and `immediate`.
  - Reset has priority over `stall`.
- When undefined:
  - The port is absent.
  - `pc` updates on every rising edge as specified above.

## Structure
- Shared package `pc_pkg`:
  - `PC_WIDTH` constant (8).
  - `pc_t` typedef (`logic [PC_WIDTH-1:0]`).
  - Enum `pc_src_e` with values `PC_SRC_SEQ` = 0 and `PC_SRC_BRANCH` = 1.
  - Default `RESET_VECTOR`.
- One sub-module, `pc_next_logic`: purely combinational. It contains the two adders and the select mux, with inputs `pc`, `immediate`, `PCSrc` and output `pc_next`.
- The top level instantiates `pc_next_logic` and contains only the register, the reset and the optional stall hold.

## Test plan
- Reset: hold `reset` = 0 for 1 cycle with `PCSrc` = 1, `immediate` = 1 -> `pc` = 0 throughout; no update occurs while reset is asserted.
- Sequential: release `reset`, `PCSrc` = 0 for 4 edges -> `pc` = 1, 2, 3, 4.
- Branch forward: from `pc` = 4, apply `PCSrc` = 1 with `immediate` = 1, then 3, then 4 on consecutive edges -> `pc` = 5, 8, 12.
- Branch backward and wrap:
  - From `pc` = 12, `immediate` = 0xF8 (−8) -> `pc` = 4.
  - From `pc` = 0xFF, `PCSrc` = 0 -> `pc` = 0x00.
  - From `pc` = 0x02, `immediate` = 0xFC -> `pc` = 0xFE.
- Asynchronous reset mid-cycle: drop `reset` to 0 halfway between edges while `pc` = 8 -> `pc` = 0 before the next edge. After release, the first edge gives `pc` = 1.
- `PC_STALL_EN` build: `stall` = 1 for 3 edges at `pc` = 5 with `PCSrc` = 1, `immediate` = 3 -> `pc` stays 5. Deassert `stall` -> `pc` = 8 at the next edge.
